// File: rtl/md_pkg.sv
// Shared types and decode helpers for the M-extension multiply/divide unit.
// Op encoding follows funct3, so the decoder is a cast once the opcode/funct7 match.
`ifndef MD_PKG_SV
`define MD_PKG_SV

package md_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } mdop_t;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    function automatic logic is_md_f(input logic [6:0] opcode, input logic [6:0] funct7);
        return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV);
    endfunction

    function automatic mdop_t gen_mdop_f(input logic [6:0] opcode, input logic [6:0] funct7,
                                         input logic [2:0] funct3);
        return is_md_f(opcode, funct7) ? mdop_t'(funct3) : MD_MUL;
    endfunction

endpackage

`endif

// File: rtl/md_div_core.sv
// Restoring-divider iteration: one quotient bit per enabled cycle on unsigned magnitudes.
// The next-state values are exported so the caller can capture the final result on the last step.
module md_div_core
    import md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            en_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quot_nxt_o,
    output logic [XLEN-1:0] rem_nxt_o
);

    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvsr_q;

    logic [XLEN:0]   rem_sh;
    logic            ge;

    // The dividend sits in the quotient register and shifts out MSB-first into the remainder.
    always_comb begin
        rem_sh     = {rem_q, quot_q[XLEN-1]};
        ge         = rem_sh >= {1'b0, dvsr_q};
        rem_nxt_o  = ge ? (rem_sh[XLEN-1:0] - dvsr_q) : rem_sh[XLEN-1:0];
        quot_nxt_o = {quot_q[XLEN-2:0], ge};
    end

    // NOTE: sequential state uses <= so every register samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            quot_q <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
        end else if (load_i) begin
            quot_q <= dividend_i;
            rem_q  <= '0;
            dvsr_q <= divisor_i;
        end else if (en_i) begin
            quot_q <= quot_nxt_o;
            rem_q  <= rem_nxt_o;
        end
    end

endmodule

// File: rtl/md_unit.sv
// Iterative RV M-extension multiply/divide unit with valid/ready on both sides and tag passthrough.
// Multiply is shift-add in a 2*XLEN product register; divide uses md_div_core. One op in flight.
module md_unit
    import md_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int TAG_W        = 5,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mdop_t             op_q, op_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept;
    logic              a_neg, b_neg, div_zero, div_ovf, special, neg_in;
    logic [XLEN-1:0]   mag_a, mag_b, special_res;
    logic [2:0]        op_bits;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_nxt, prod_fix;
    logic [XLEN-1:0]   quot_nxt, rem_nxt, calc_res;

    assign accept  = in_valid_i && (state_q == ST_IDLE) && !flush_i;
    assign op_bits = op_q;

    // Operand conditioning: magnitudes plus the sign the final result must carry.
    always_comb begin
        a_neg    = (op_i inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) && rs1_i[XLEN-1];
        b_neg    = (op_i inside {MD_MULH, MD_DIV, MD_REM}) && rs2_i[XLEN-1];
        mag_a    = a_neg ? -rs1_i : rs1_i;
        mag_b    = b_neg ? -rs2_i : rs2_i;
        div_zero = (rs2_i == '0);
        div_ovf  = (op_i inside {MD_DIV, MD_REM}) && (rs1_i == {1'b1, {(XLEN-1){1'b0}}})
                   && (rs2_i == '1);
        special  = op_i[2] && (div_zero || div_ovf);

        if (div_zero)
            special_res = op_i[1] ? rs1_i : '1;
        else
            special_res = op_i[1] ? '0 : rs1_i;

        // A zero divisor must yield all-ones for DIV, so its quotient is never negated.
        if (!op_i[2])
            neg_in = a_neg ^ b_neg;
        else if (op_i[1])
            neg_in = a_neg;
        else
            neg_in = (a_neg ^ b_neg) && !div_zero;
    end

    md_div_core #(.XLEN(XLEN)) u_div (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .en_i       ((state_q == ST_CALC) && op_bits[2]),
        .dividend_i (mag_a),
        .divisor_i  (mag_b),
        .quot_nxt_o (quot_nxt),
        .rem_nxt_o  (rem_nxt)
    );

    always_comb begin
        mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_nxt = {mul_sum, prod_q[XLEN-1:1]};
        prod_fix = neg_q ? -prod_nxt : prod_nxt;

        case (op_q)
            MD_MUL:                       calc_res = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: calc_res = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              calc_res = neg_q ? -quot_nxt : quot_nxt;
            default:                      calc_res = neg_q ? -rem_nxt : rem_nxt;
        endcase
    end

    // NOTE: every _d takes its _q value first, so no path through the case leaves a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        tag_d    = tag_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = mdop_t'(op_i);
                    tag_d   = tag_i;
                    neg_d   = neg_in;
                    mcand_d = mag_a;
                    prod_d  = {{XLEN{1'b0}}, mag_b};
                    if (FAST_SPECIAL && special) begin
                        result_d = special_res;
                        state_d  = ST_DONE;
                    end else begin
                        cnt_d   = CNT_W'(XLEN);
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                prod_d = prod_nxt;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    result_d = calc_res;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready_i)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= MD_MUL;
            tag_q    <= '0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            prod_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            result_q <= result_d;
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_DONE);
    assign busy_o      = (state_q != ST_IDLE);
    assign result_o    = result_q;
    assign tag_o       = tag_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: one instance with FAST_SPECIAL=1 and one with FAST_SPECIAL=0.
module tb_md_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             f_in_valid, s_in_valid;
    logic [2:0]       op;
    logic [XLEN-1:0]  rs1, rs2;
    logic [TAG_W-1:0] tag;
    logic             out_ready;

    logic             f_in_ready, f_out_valid, f_busy;
    logic [XLEN-1:0]  f_result;
    logic [TAG_W-1:0] f_tag;
    logic             s_in_ready, s_out_valid, s_busy;
    logic [XLEN-1:0]  s_result;
    logic [TAG_W-1:0] s_tag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    md_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .FAST_SPECIAL(1'b1)) dut_fast (
        .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(f_in_valid), .in_ready_o(f_in_ready),
        .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .tag_i(tag), .out_valid_o(f_out_valid),
        .out_ready_i(out_ready), .result_o(f_result), .tag_o(f_tag), .busy_o(f_busy)
    );

    md_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .FAST_SPECIAL(1'b0)) dut_slow (
        .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
        .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .tag_i(tag), .out_valid_o(s_out_valid),
        .out_ready_i(out_ready), .result_o(s_result), .tag_o(s_tag), .busy_o(s_busy)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait for out_valid (bounded), check latency/result/tag, then the handshake.
    task automatic run_op(input bit slow, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] t, input logic [31:0] exp_res,
                          input int exp_lat, input string name);
        int lat;
        check({name, "_in_ready"}, 32'(slow ? s_in_ready : f_in_ready), 32'd1);
        op        = o;
        rs1       = a;
        rs2       = b;
        tag       = t;
        out_ready = 1'b1;
        if (slow) s_in_valid = 1'b1;
        else      f_in_valid = 1'b1;
        tick();
        f_in_valid = 1'b0;
        s_in_valid = 1'b0;
        lat = 1;
        while (!(slow ? s_out_valid : f_out_valid) && lat < 100) begin
            tick();
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_result"}, slow ? s_result : f_result, exp_res);
        check({name, "_tag"}, 32'(slow ? s_tag : f_tag), 32'(t));
        tick();
        check({name, "_valid_after_hs"}, 32'(slow ? s_out_valid : f_out_valid), 32'd0);
        check({name, "_ready_after_hs"}, 32'(slow ? s_in_ready : f_in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        rst        = 1'b1;
        flush      = 1'b0;
        f_in_valid = 1'b0;
        s_in_valid = 1'b0;
        op         = 3'd0;
        rs1        = '0;
        rs2        = '0;
        tag        = '0;
        out_ready  = 1'b0;
        tick();
        tick();
        check("reset_in_ready", 32'(f_in_ready), 32'd1);
        check("reset_out_valid", 32'(f_out_valid), 32'd0);
        check("reset_busy", 32'(f_busy), 32'd0);
        check("reset_result", f_result, 32'd0);
        check("reset_tag", 32'(f_tag), 32'd0);
        rst = 1'b0;
        tick();

        // Multiply family
        run_op(1'b0, 3'd0, 32'd7,        32'hFFFFFFFD, 5'h1A, 32'hFFFFFFEB, 33, "mul");
        run_op(1'b0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h03, 32'hFFFFFFFE, 33, "mulhu");
        run_op(1'b0, 3'd1, 32'h80000000, 32'h80000000, 5'h04, 32'h40000000, 33, "mulh");
        run_op(1'b0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h05, 32'hFFFFFFFF, 33, "mulhsu");

        // Divide family
        run_op(1'b0, 3'd4, 32'hFFFFFFF9, 32'd2, 5'h06, 32'hFFFFFFFD, 33, "div_neg");
        run_op(1'b0, 3'd6, 32'hFFFFFFF9, 32'd2, 5'h07, 32'hFFFFFFFF, 33, "rem_neg");
        run_op(1'b0, 3'd5, 32'd100,      32'd7, 5'h08, 32'd14,       33, "divu");
        run_op(1'b0, 3'd7, 32'd100,      32'd7, 5'h09, 32'd2,        33, "remu");

        // Special cases, fast path then iterated path
        run_op(1'b0, 3'd4, 32'd5,        32'd0,        5'h0A, 32'hFFFFFFFF, 1, "f_div0");
        run_op(1'b0, 3'd6, 32'd5,        32'd0,        5'h0B, 32'd5,        1, "f_rem0");
        run_op(1'b0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'h0C, 32'h80000000, 1, "f_divovf");
        run_op(1'b0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'h0D, 32'd0,        1, "f_removf");
        run_op(1'b1, 3'd4, 32'd5,        32'd0,        5'h0A, 32'hFFFFFFFF, 33, "s_div0");
        run_op(1'b1, 3'd6, 32'd5,        32'd0,        5'h0B, 32'd5,        33, "s_rem0");
        run_op(1'b1, 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'h0C, 32'h80000000, 33, "s_divovf");
        run_op(1'b1, 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'h0D, 32'd0,        33, "s_removf");

        // Back-pressure: result held 5 cycles while new requests are ignored
        op = 3'd0; rs1 = 32'd6; rs2 = 32'd7; tag = 5'h09; out_ready = 1'b0;
        f_in_valid = 1'b1;
        tick();
        f_in_valid = 1'b0;
        lat = 1;
        while (!f_out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("hold_latency", 32'(lat), 32'd33);
        op = 3'd5; rs1 = 32'd1; rs2 = 32'd1; tag = 5'h03; f_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_result", f_result, 32'd42);
            check("hold_tag", 32'(f_tag), 32'h09);
            check("hold_in_ready", 32'(f_in_ready), 32'd0);
            check("hold_out_valid", 32'(f_out_valid), 32'd1);
        end
        f_in_valid = 1'b0;
        out_ready  = 1'b1;
        tick();
        check("release_out_valid", 32'(f_out_valid), 32'd0);
        check("release_in_ready", 32'(f_in_ready), 32'd1);

        // Flush together with a request in IDLE: nothing is accepted
        op = 3'd0; rs1 = 32'd2; rs2 = 32'd2; flush = 1'b1; f_in_valid = 1'b1;
        tick();
        flush = 1'b0; f_in_valid = 1'b0;
        check("flush_idle_busy", 32'(f_busy), 32'd0);
        check("flush_idle_in_ready", 32'(f_in_ready), 32'd1);

        // Flush mid-DIV with the counter at 10, then a back-to-back MUL
        op = 3'd4; rs1 = 32'd100; rs2 = 32'd7; tag = 5'h04; f_in_valid = 1'b1;
        tick();
        f_in_valid = 1'b0;
        repeat (22) tick();
        check("flush_calc_busy_before", 32'(f_busy), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_calc_out_valid", 32'(f_out_valid), 32'd0);
        check("flush_calc_busy", 32'(f_busy), 32'd0);
        check("flush_calc_in_ready", 32'(f_in_ready), 32'd1);
        run_op(1'b0, 3'd0, 32'd3, 32'd4, 5'h11, 32'd12, 33, "mul_after_flush");

        // Flush wins over out_ready in DONE
        op = 3'd4; rs1 = 32'd5; rs2 = 32'd0; tag = 5'h12; out_ready = 1'b0; f_in_valid = 1'b1;
        tick();
        f_in_valid = 1'b0;
        check("flush_done_valid_before", 32'(f_out_valid), 32'd1);
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_done_out_valid", 32'(f_out_valid), 32'd0);
        check("flush_done_in_ready", 32'(f_in_ready), 32'd1);

        // Reset mid-CALC returns every output to its reset value
        op = 3'd5; rs1 = 32'd100; rs2 = 32'd7; tag = 5'h1F; f_in_valid = 1'b1;
        tick();
        f_in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_calc_in_ready", 32'(f_in_ready), 32'd1);
        check("rst_calc_out_valid", 32'(f_out_valid), 32'd0);
        check("rst_calc_busy", 32'(f_busy), 32'd0);
        check("rst_calc_result", f_result, 32'd0);
        check("rst_calc_tag", 32'(f_tag), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised, iterative RV M-extension multiply/divide unit; successor to the single-cycle combinational ALU op path.
- Sits beside the ALU in the execute stage, with a valid/ready handshake on both sides and a tag passthrough so the pipeline can stall on it.
- Shared shift-add / restoring-division datapath; one operation in flight.

Parameters:
- XLEN, 32, operand/result width (≥8, power of 2).
- TAG_W, 5, width of opaque tag (typically rd index) carried with the op.
- FAST_SPECIAL, 1, when 1, div-by-zero and signed overflow complete with no iteration.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush_i  in  1  abort any in-flight or held op
- in_valid_i  in  1  op request valid
- in_ready_o  out  1  unit can accept (state IDLE)
- op_i  in  3  mdop_t: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- rs1_i  in  XLEN  operand A / dividend
- rs2_i  in  XLEN  operand B / divisor
- tag_i  in  TAG_W  passthrough tag
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- result_o  out  XLEN  result
- tag_o  out  TAG_W  tag of result
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, in_ready_o=1, out_valid_o=0, busy_o=0, result_o=0, tag_o=0, counter=0. A reset mid-operation discards the op with no output.
- States: IDLE, CALC, DONE.
- IDLE -> accept when in_valid_i & in_ready_o (cycle N). Latch op, tag, operand magnitudes (abs for signed operands: MULH both, MULHSU rs1 only, DIV/REM both), result-sign flags.
  - If FAST_SPECIAL and the op is div/rem with rs2=0 or signed overflow: -> DONE; else -> CALC, counter=XLEN.
- CALC: one iteration per cycle (multiply: shift-add into 2*XLEN product; divide: restoring, 1 quotient bit/cycle); counter decrements; at counter==1 -> DONE with sign fixup applied.
- Latency:
  - Normal: out_valid_o rises at cycle N+XLEN+1.
  - Special cases (FAST_SPECIAL=1): cycle N+1.
  - FAST_SPECIAL=0: special cases iterate normally and must still produce the spec values below.
- DONE: out_valid_o=1; result_o/tag_o stable until out_ready_i. On handshake -> IDLE; in_ready_o rises the following cycle (no same-cycle accept in DONE).
- Results:
  - MUL: low XLEN of product.
  - MULH/MULHSU/MULHU: high XLEN of the signed×signed, signed×unsigned, unsigned×unsigned product respectively. Negate the 2*XLEN product when signs differ.
  - DIV/DIVU: quotient truncated toward zero. REM/REMU: remainder carries the dividend's sign.
  - Divide by zero: DIV/DIVU = all ones; REM/REMU = rs1.
  - Signed overflow (rs1=-2^(XLEN-1), rs2=-1): DIV = rs1; REM = 0.
- Flush:
  - flush_i in any state -> IDLE next cycle with out_valid_o=0.
  - flush_i with in_valid_i in the same IDLE cycle: no accept.
  - flush_i has priority over out_ready_i.
- in_ready_o is 0 in CALC and DONE; inputs are ignored there.

Decomposition:
- md_pkg (own include guard, includes riscv.svh):
  - mdop_t enum, 3 bits, ordered as funct3.
  - FUNCT7_MULDIV constant (7'b0000001).
  - gen_mdop_f(opcode, funct7, funct3) returning mdop_t, plus is_md_f predicate.
  - These mirror the alu_pkg decode style.
- Sub-module md_div_core: XLEN-parametrised restoring-divider iteration step (remainder/quotient registers, one bit per enable). Multiply stays in md_unit.

Test Plan:
- MUL 7 × 0xFFFFFFFD (XLEN=32) -> result 0xFFFFFFEB, out_valid at N+33, tag echoed.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, both at N+1. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0 at N+1. Repeat with FAST_SPECIAL=0: same values at N+33.
- Hold out_ready_i=0 for 5 cycles in DONE -> result_o/tag_o stable, in_ready_o=0. Release -> one handshake, then in_ready_o=1 next cycle.
- Assert flush_i at counter=10 mid-DIV -> IDLE next cycle with no out_valid. Then a back-to-back MUL 3×4 -> 12. Also assert rst mid-CALC -> all outputs at reset values next cycle.
